// File: rtl/audio_voice_mixer_i2s.sv
// Multi-voice PCM mixer with per-voice FIFOs feeding an I2S / left-justified DACDAT serializer.
// Build with AUDIO_MIX_SATURATE_EN defined to clamp the mix and report sat_flag; otherwise the mix wraps.
module audio_voice_mixer_i2s #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(NUM_VOICES)-1:0] in_voice,
  input  logic [SAMPLE_W-1:0]           in_data,
  input  logic [NUM_VOICES-1:0]         voice_en,
  input  logic                          mode_i2s,
  input  logic                          clear_status,
  input  logic                          aud_bclk,
  input  logic                          aud_daclrck,
  output logic                          aud_dacdat,
  output logic [NUM_VOICES-1:0]         underflow,
  output logic                          sat_flag
);

  localparam int unsigned VW    = $clog2(NUM_VOICES);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned CNT_W = $clog2(SAMPLE_W + 1);
`ifdef AUDIO_MIX_SATURATE_EN
  localparam int unsigned SUM_W = SAMPLE_W + VW;
`else
  // Wrap-around keeps only the low bits, so the guard bits are never needed.
  localparam int unsigned SUM_W = SAMPLE_W;
`endif

  // [0],[1] synchronizer stages, [2] previous synchronized value.
  logic [2:0] bclk_q, lrck_q;
  logic       bclk_fall, frame_start, lrck_rise, right_start;
  logic       started_q, started_d;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bclk_q <= '0;
      lrck_q <= '0;
    end else begin
      bclk_q <= {bclk_q[1:0], aud_bclk};
      lrck_q <= {lrck_q[1:0], aud_daclrck};
    end
  end

  assign bclk_fall   = bclk_q[2] & ~bclk_q[1];
  assign frame_start = lrck_q[2] & ~lrck_q[1];
  assign lrck_rise   = ~lrck_q[2] & lrck_q[1];
  assign right_start = lrck_rise & started_q;

  logic [SAMPLE_W-1:0]                 mem_q [NUM_VOICES][FIFO_DEPTH];
  logic [NUM_VOICES-1:0][AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NUM_VOICES-1:0][SAMPLE_W-1:0] head;
  logic [NUM_VOICES-1:0]               full, empty, push, pop;

  always_comb begin
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      empty[v] = (wr_ptr_q[v] == rd_ptr_q[v]);
      full[v]  = (wr_ptr_q[v][AW] != rd_ptr_q[v][AW]) &&
                 (wr_ptr_q[v][AW-1:0] == rd_ptr_q[v][AW-1:0]);
      head[v]  = mem_q[v][rd_ptr_q[v][AW-1:0]];
    end
  end

  assign in_ready = ~full[in_voice];

  always_comb begin
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      push[v]     = in_valid && in_ready && (in_voice == VW'(v));
      pop[v]      = frame_start && voice_en[v] && !empty[v];
      wr_ptr_d[v] = wr_ptr_q[v] + PW'(push[v]);
      rd_ptr_d[v] = rd_ptr_q[v] + PW'(pop[v]);
    end
  end

  always_ff @(posedge clk_clk) begin
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (push[v]) mem_q[v][wr_ptr_q[v][AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  logic signed [SUM_W-1:0] sum;
  logic [SAMPLE_W-1:0]     mix_d, mix_q;

  always_comb begin
    sum = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (voice_en[v] && !empty[v]) sum = sum + SUM_W'($signed(head[v]));
    end
  end

`ifdef AUDIO_MIX_SATURATE_EN
  logic clip;
  logic sat_q, sat_d;

  always_comb begin
    // Out of range whenever the guard bits and the sample sign bit disagree.
    clip = !((&sum[SUM_W-1:SAMPLE_W-1]) || !(|sum[SUM_W-1:SAMPLE_W-1]));
    if (clip) begin
      mix_d = sum[SUM_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else begin
      mix_d = sum[SAMPLE_W-1:0];
    end
    sat_d = (clear_status ? 1'b0 : sat_q) | (frame_start & clip);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) sat_q <= 1'b0;
    else                sat_q <= sat_d;
  end

  assign sat_flag = sat_q;
`else
  assign mix_d    = sum;
  assign sat_flag = 1'b0;
`endif

  logic [NUM_VOICES-1:0] uf_q, uf_d;
  assign uf_d      = (clear_status ? '0 : uf_q) | ({NUM_VOICES{frame_start}} & voice_en & empty);
  assign underflow = uf_q;

  logic [SAMPLE_W-1:0] sh_q, sh_d, ld;
  logic [CNT_W-1:0]    left_q, left_d;
  logic                dac_q, dac_d, mode_q, mode_d, lj, out_bit;

  always_comb begin
    sh_d      = sh_q;
    left_d    = left_q;
    dac_d     = dac_q;
    mode_d    = frame_start ? mode_i2s : mode_q;
    started_d = started_q | frame_start;
    out_bit   = (left_q != '0) ? sh_q[SAMPLE_W-1] : 1'b0;
    lj        = frame_start ? !mode_i2s : !mode_q;
    ld        = frame_start ? mix_d : mix_q;
    if (frame_start || right_start) begin
      if (lj) begin
        dac_d  = ld[SAMPLE_W-1];
        sh_d   = ld << 1;
        left_d = CNT_W'(SAMPLE_W - 1);
      end else begin
        // I2S: the coincident BCLK fall still belongs to the previous slot.
        if (bclk_fall) dac_d = out_bit;
        sh_d   = ld;
        left_d = CNT_W'(SAMPLE_W);
      end
    end else if (bclk_fall) begin
      dac_d = out_bit;
      if (left_q != '0) begin
        sh_d   = sh_q << 1;
        left_d = left_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sh_q      <= '0;
      left_q    <= '0;
      dac_q     <= 1'b0;
      mode_q    <= 1'b1;
      started_q <= 1'b0;
      mix_q     <= '0;
      uf_q      <= '0;
    end else begin
      sh_q      <= sh_d;
      left_q    <= left_d;
      dac_q     <= dac_d;
      mode_q    <= mode_d;
      started_q <= started_d;
      mix_q     <= frame_start ? mix_d : mix_q;
      uf_q      <= uf_d;
    end
  end

  assign aud_dacdat = dac_q;

endmodule

// File: tb/tb_audio_voice_mixer_i2s.sv
// Directed bench for audio_voice_mixer_i2s: drives codec BCLK/LRCK frames and checks DACDAT slots and flags.
module tb_audio_voice_mixer_i2s;

  localparam int SLOT = 20;

  logic        clk_clk       = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        in_valid      = 1'b0;
  logic        in_ready;
  logic [1:0]  in_voice      = 2'd0;
  logic [15:0] in_data       = 16'h0;
  logic [3:0]  voice_en      = 4'h0;
  logic        mode_i2s      = 1'b1;
  logic        clear_status  = 1'b0;
  logic        aud_bclk      = 1'b1;
  logic        aud_daclrck   = 1'b1;
  logic        aud_dacdat;
  logic [3:0]  underflow;
  logic        sat_flag;

  int total  = 0;
  int bad    = 0;
  int v2_acc = 0;
  logic cap [2*SLOT];

  always #5 clk_clk = ~clk_clk;

  audio_voice_mixer_i2s #(
    .NUM_VOICES(4),
    .SAMPLE_W  (16),
    .FIFO_DEPTH(16)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_voice     (in_voice),
    .in_data      (in_data),
    .voice_en     (voice_en),
    .mode_i2s     (mode_i2s),
    .clear_status (clear_status),
    .aud_bclk     (aud_bclk),
    .aud_daclrck  (aud_daclrck),
    .aud_dacdat   (aud_dacdat),
    .underflow    (underflow),
    .sat_flag     (sat_flag)
  );

  always @(posedge clk_clk) begin
    if (reset_reset_n && in_valid && in_ready && in_voice == 2'd2) v2_acc <= v2_acc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] v, input logic [15:0] d);
    int n;
    n = 0;
    @(negedge clk_clk);
    in_valid = 1'b1; in_voice = v; in_data = d;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk_clk);
      n++;
    end
    chk("push_ready", 32'(in_ready), 32'd1);
    @(posedge clk_clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_bits(input int n, input logic lr, output logic any1);
    any1 = 1'b0;
    @(negedge clk_clk);
    for (int i = 0; i < n; i++) begin
      aud_bclk = 1'b0; aud_daclrck = lr;
      #59 any1 = any1 | aud_dacdat;
      #1 aud_bclk = 1'b1;
      #60;
    end
  endtask

  task automatic run_frame();
    @(negedge clk_clk);
    for (int i = 0; i < 2*SLOT; i++) begin
      aud_bclk = 1'b0; aud_daclrck = (i >= SLOT);
      #59 cap[i] = aud_dacdat;
      #1 aud_bclk = 1'b1;
      #60;
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] exp, input bit lj);
    logic [15:0] l, r;
    logic pad;
    int off;
    off = lj ? 0 : 1;
    pad = 1'b0;
    l = 16'h0; r = 16'h0;
    for (int i = 0; i < SLOT; i++) begin
      if (i >= off && i < off + 16) begin
        l[15-(i-off)] = cap[i];
        r[15-(i-off)] = cap[SLOT+i];
      end else begin
        pad = pad | cap[i] | cap[SLOT+i];
      end
    end
    chk({tag, "_left"},  32'(l),   32'(exp));
    chk({tag, "_right"}, 32'(r),   32'(exp));
    chk({tag, "_pad"},   32'(pad), 32'd0);
  endtask

  task automatic pulse_clear();
    @(negedge clk_clk);
    clear_status = 1'b1;
    @(negedge clk_clk);
    clear_status = 1'b0;
    #1;
  endtask

  initial begin
    logic any1;
    repeat (3) @(negedge clk_clk);
    run_bits(6, 1'b1, any1);
    chk("rst_dacdat",    32'(aud_dacdat), 32'd0);
    chk("rst_underflow", 32'(underflow),  32'd0);
    chk("rst_sat",       32'(sat_flag),   32'd0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    voice_en = 4'b0001;
    mode_i2s = 1'b1;
    push(2'd0, 16'h1234);
    run_bits(8, 1'b1, any1);
    chk("partial_frame_zero", 32'(any1), 32'd0);

    run_frame();
    check_frame("i2s_single", 16'h1234, 1'b0);
    chk("single_no_underflow", 32'(underflow), 32'd0);

    push(2'd0, 16'h0ABC);
    voice_en = 4'b0011;
    run_frame();
    check_frame("uf_mix", 16'h0ABC, 1'b0);
    chk("uf_flag", 32'(underflow), 32'h2);
    pulse_clear();
    chk("uf_clear", 32'(underflow), 32'd0);

    push(2'd0, 16'h7000);
    push(2'd1, 16'h7000);
    run_frame();
`ifdef AUDIO_MIX_SATURATE_EN
    check_frame("sat_pos", 16'h7FFF, 1'b0);
    chk("sat_pos_flag", 32'(sat_flag), 32'd1);
`else
    check_frame("wrap_pos", 16'hE000, 1'b0);
    chk("wrap_pos_flag", 32'(sat_flag), 32'd0);
`endif
    pulse_clear();
    chk("sat_clear", 32'(sat_flag), 32'd0);

    push(2'd0, 16'h8000);
    push(2'd1, 16'h8000);
    run_frame();
`ifdef AUDIO_MIX_SATURATE_EN
    check_frame("sat_neg", 16'h8000, 1'b0);
    chk("sat_neg_flag", 32'(sat_flag), 32'd1);
`else
    check_frame("wrap_neg", 16'h0000, 1'b0);
    chk("wrap_neg_flag", 32'(sat_flag), 32'd0);
`endif
    chk("sat_no_underflow", 32'(underflow), 32'd0);

    voice_en = 4'b0000;
    for (int k = 0; k < 16; k++) push(2'd2, 16'(16'h0100 + k));
    @(negedge clk_clk);
    in_voice = 2'd2;
    #1 chk("full_v2_ready", 32'(in_ready), 32'd0);
    in_voice = 2'd0;
    #1 chk("v0_ready_while_v2_full", 32'(in_ready), 32'd1);
    in_voice = 2'd2; in_data = 16'h0555; in_valid = 1'b1;
    repeat (5) @(negedge clk_clk);
    chk("held_blocked", 32'(v2_acc), 32'd16);
    voice_en = 4'b0100;
    run_frame();
    @(negedge clk_clk);
    chk("held_accepted", 32'(v2_acc), 32'd17);
    chk("refull_v2_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    check_frame("fifo_pop", 16'h0100, 1'b0);

    mode_i2s = 1'b0;
    voice_en = 4'b0001;
    push(2'd0, 16'h8001);
    run_frame();
    check_frame("lj", 16'h8001, 1'b1);
    chk("final_underflow", 32'(underflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/audio_voice_mixer_i2s.md
# audio_voice_mixer_i2s

Multi-voice PCM mixer and I2S/left-justified serializer for the DE1-SoC WM8731 DAC path. It generalises the single audio output to NUM_VOICES independent sample streams (music, jump, collision effects), each with its own buffer, and mixes them once per codec frame. The codec is bit-clock and LR-clock master, and this block only drives DACDAT. It sits between the game's Avalon-mapped sound logic and the AUD_BCLK/AUD_DACLRCK/AUD_DACDAT pins.

## Interface
- NUM_VOICES, 4: number of input voices (≥2).
- SAMPLE_W, 16: signed sample width, two's complement.
- FIFO_DEPTH, 16: per-voice FIFO entries (power of two).
- clk_clk  in  1  system clock, 50 MHz.
- reset_reset_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  sample offered.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- in_voice  in  $clog2(NUM_VOICES)  target voice of the offered sample.
- in_data  in  SAMPLE_W  sample value.
- voice_en  in  NUM_VOICES  enabled voices are popped each frame; disabled voices contribute 0.
- mode_i2s  in  1  1 = I2S (one-BCLK delay), 0 = left-justified; sampled at each frame start.
- clear_status  in  1  one-cycle pulse that clears the sticky flags.
- aud_bclk  in  1  codec bit clock (asynchronous).
- aud_daclrck  in  1  codec LR clock (asynchronous); 0 = left, 1 = right.
- aud_dacdat  out  1  serial DAC data.
- underflow  out  NUM_VOICES  sticky flag; the enabled voice was empty at a pop.
- sat_flag  out  1  sticky flag; a mix result was clipped.

## Operation
- aud_bclk and aud_daclrck each pass through a 2-FF synchronizer. Falling and rising edges are detected from the synchronized value and the previous value.
- Frame start is the synchronized falling edge of aud_daclrck. Right-channel start is the synchronized rising edge.
- Per-voice FIFO:
  - in_ready = !full[in_voice]. in_ready does not account for a same-cycle pop.
  - When push and pop hit the same voice in the same cycle, both occur. A pop on an empty FIFO yields 0, and the pushed sample is stored.
- Pop/mix at frame start:
  - Every enabled voice pops one entry.
  - An enabled voice that is empty contributes 0 and sets its underflow bit.
  - Sum is a signed value of width SAMPLE_W+$clog2(NUM_VOICES) and is reduced to SAMPLE_W (see Configuration).
  - The same mixed value is sent on both the left and right channels of the frame.
- Serializer:
  - The shift register is loaded with the mix at frame start and reloaded with the same value at right-channel start.
  - Data is shifted MSB first, one bit per synchronized BCLK falling edge.
  - After SAMPLE_W bits, and for all padding bits, aud_dacdat is 0.
  - I2S mode: the MSB is driven at the first BCLK falling edge after the LRCK edge.
  - Left-justified mode: the MSB is driven in the same cycle the LRCK edge is detected.
- After reset, aud_dacdat stays 0 until the first complete frame start. A partial frame in progress at reset release is ignored.
- Sticky flags are cleared by clear_status. If a set event and clear_status occur in the same cycle, the set wins.

## Timing
- Reset values: aud_dacdat=0, underflow=0, sat_flag=0, all FIFOs empty. in_ready=1 after release.
- Edge-detect latency is 3 clk_clk from a pin edge.
- The mix is registered 1 clk after frame-start detection. The shift register is loaded in that same cycle.
- aud_dacdat changes only on detected BCLK falling edges, or on the load cycle in left-justified mode.
- Push-to-full: in_ready falls the cycle after the FIFO_DEPTH-th accept. It rises the cycle after a pop.
- Requires clk_clk ≥ 8× BCLK.

## Configuration
- AUDIO_MIX_SATURATE_EN defined:
  - Sums above 2^(SAMPLE_W-1)-1 clamp to that value.
  - Sums below -2^(SAMPLE_W-1) clamp to that value.
  - Any clamp sets sat_flag.
- AUDIO_MIX_SATURATE_EN undefined:
  - The low SAMPLE_W bits are kept (wrap-around).
  - sat_flag is tied to 0.

## Test plan
- Reset: hold reset_reset_n low mid-frame with BCLK running -> aud_dacdat=0, flags=0. After release, in_ready=1 and data stays 0 until the next LRCK falling edge.
- Single voice, I2S: voice_en=4'b0001, push 16'h1234 to voice 0 -> left and right slots each carry 0x1234 MSB first starting on the 2nd BCLK falling edge after the LRCK edge, then zeros. underflow=0.
- Underflow: voice_en=4'b0011, only voice 0 holds data -> mix equals voice 0, underflow=4'b0010. clear_status -> underflow=0.
- Saturation: voices 0 and 1 each hold 16'h7000 -> with the macro, output 16'h7FFF and sat_flag=1. Without the macro, output 16'hE000 and sat_flag=0. Voices at 16'h8000 + 16'h8000 with the macro -> 16'h8000.
- FIFO full: 16 pushes to voice 2 with no frames -> in_ready=0 with in_voice=2. A 17th sample held valid is not accepted until the next frame pop, then it is accepted. in_voice=0 still shows in_ready=1.
- Left-justified: mode_i2s=0, voice 0 holds 16'h8001 -> MSB 1 appears within 1 clk of the detected LRCK edge, the 16th bit is 1, and bit 17 onward is 0.
